rob_ring: RTL and testbench

Parametrised reorder buffer for the out-of-order core: a circular queue of `NUM_ROB_ENTS` entries. It allocates up to `DISP_WIDTH` entries per cycle at dispatch and accepts up to `NUM_CPL` completion writebacks per cycle from the functional units. It retires up to `RETIRE_WIDTH` completed entries per cycle in program order, and flushes the whole window when a retiring entry carries an exception or branch mispredict. It sits between dispatch/rename and the architectural commit logic.

---
 rtl/rob_ring.sv | 124 ++++++++++++
 tb/tb_rob_ring.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer with multi-lane dispatch, completion, in-order retire and fault flush.
module rob_ring #(
  parameter int NUM_ROB_ENTS = 64,
  parameter int DISP_WIDTH   = 2,
  parameter int RETIRE_WIDTH = 4,
  parameter int NUM_CPL      = 4,
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 128,
  localparam int IW = $clog2(NUM_ROB_ENTS),
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DISP_WIDTH-1:0]                    disp_valid,
  input  logic [DISP_WIDTH-1:0][AW-1:0]            disp_dst_areg,
  input  logic [DISP_WIDTH-1:0][PW-1:0]            disp_dst_preg,
  input  logic [DISP_WIDTH-1:0][31:0]              disp_pc,
  output logic                                     disp_ready,
  output logic [DISP_WIDTH-1:0][IW-1:0]            disp_rob_idx,
  input  logic [NUM_CPL-1:0]                       cpl_valid,
  input  logic [NUM_CPL-1:0][IW-1:0]               cpl_rob_idx,
  input  logic [NUM_CPL-1:0]                       cpl_exception,
  input  logic [NUM_CPL-1:0]                       cpl_br_mispred,
  output logic [RETIRE_WIDTH-1:0]                  ret_valid,
  output logic [RETIRE_WIDTH-1:0][AW-1:0]          ret_dst_areg,
  output logic [RETIRE_WIDTH-1:0][PW-1:0]          ret_dst_preg,
  output logic [RETIRE_WIDTH-1:0][31:0]            ret_pc,
  output logic [RETIRE_WIDTH-1:0]                  ret_exception,
  output logic [RETIRE_WIDTH-1:0]                  ret_br_mispred,
  output logic                                     flush,
  output logic [IW-1:0]                            flush_rob_idx,
  output logic [IW:0]                              count
);
  logic [IW:0]                          r_head, r_tail;
  logic [NUM_ROB_ENTS-1:0]              r_valid, r_done, r_exc, r_bm;
  logic [AW-1:0]                        r_areg [NUM_ROB_ENTS];
  logic [PW-1:0]                        r_preg [NUM_ROB_ENTS];
  logic [31:0]                          r_pc   [NUM_ROB_ENTS];
  logic [RETIRE_WIDTH-1:0][IW-1:0]      w_ret_idx;
  logic [NUM_ROB_ENTS-1:0]              w_alloc, w_ret_clr, w_cpl_hit, w_cpl_exc, w_cpl_bm;
  logic [IW:0]                          w_n_disp, w_n_ret;
  logic                                 w_stop;

  assign count      = r_tail - r_head;
  assign disp_ready = !flush && ({1'b0, count} <= (IW+2)'(NUM_ROB_ENTS - DISP_WIDTH));

  always_comb begin
    w_n_disp = '0;
    w_alloc  = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_rob_idx[i] = r_tail[IW-1:0] + IW'(i);
      w_n_disp        = w_n_disp + (IW+1)'(disp_valid[i]);
      if (disp_ready && disp_valid[i]) w_alloc[disp_rob_idx[i]] = 1'b1;
    end
  end

  // Completions are merged per entry first so two ports hitting one entry OR their flags.
  always_comb begin
    w_cpl_hit = '0;
    w_cpl_exc = '0;
    w_cpl_bm  = '0;
    for (int p = 0; p < NUM_CPL; p++)
      if (cpl_valid[p] && r_valid[cpl_rob_idx[p]]) begin
        w_cpl_hit[cpl_rob_idx[p]] = 1'b1;
        w_cpl_exc[cpl_rob_idx[p]] = w_cpl_exc[cpl_rob_idx[p]] | cpl_exception[p];
        w_cpl_bm[cpl_rob_idx[p]]  = w_cpl_bm[cpl_rob_idx[p]] | cpl_br_mispred[p];
      end
  end

  // A faulting entry closes the retire group, so it is always the last valid lane.
  always_comb begin
    ret_valid     = '0;
    flush         = 1'b0;
    flush_rob_idx = '0;
    w_n_ret       = '0;
    w_ret_clr     = '0;
    w_stop        = 1'b0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      w_ret_idx[k]      = r_head[IW-1:0] + IW'(k);
      ret_dst_areg[k]   = r_areg[w_ret_idx[k]];
      ret_dst_preg[k]   = r_preg[w_ret_idx[k]];
      ret_pc[k]         = r_pc[w_ret_idx[k]];
      ret_exception[k]  = r_exc[w_ret_idx[k]];
      ret_br_mispred[k] = r_bm[w_ret_idx[k]];
      if (!w_stop && (IW+1)'(k) < count && r_valid[w_ret_idx[k]] && r_done[w_ret_idx[k]]) begin
        ret_valid[k]            = 1'b1;
        w_n_ret                 = w_n_ret + 1'b1;
        w_ret_clr[w_ret_idx[k]] = 1'b1;
        if (r_exc[w_ret_idx[k]] || r_bm[w_ret_idx[k]]) begin
          flush         = 1'b1;
          flush_rob_idx = w_ret_idx[k];
          w_stop        = 1'b1;
        end
      end else w_stop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      r_bm    <= '0;
    end else begin
      r_head  <= r_head + w_n_ret;
      r_tail  <= disp_ready ? r_tail + w_n_disp : r_tail;
      r_valid <= (r_valid & ~w_ret_clr) | w_alloc;
      r_done  <= (r_done | w_cpl_hit) & ~w_alloc;
      r_exc   <= (r_exc | w_cpl_exc) & ~w_alloc;
      r_bm    <= (r_bm | w_cpl_bm) & ~w_alloc;
    end
  end

  always_ff @(posedge clk)
    for (int i = 0; i < DISP_WIDTH; i++)
      if (disp_ready && disp_valid[i]) begin
        r_areg[disp_rob_idx[i]] <= disp_dst_areg[i];
        r_preg[disp_rob_idx[i]] <= disp_dst_preg[i];
        r_pc[disp_rob_idx[i]]   <= disp_pc[i];
      end
endmodule

// File: tb/tb_rob_ring.sv
// tb_rob_ring: reorder-buffer bench; a queue of dispatched entries predicts retire order, flush and occupancy.
module tb_rob_ring;
  localparam int N = 64, DW = 2, RW = 4, NC = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0]            disp_valid;
  logic [DW-1:0][4:0]       disp_dst_areg;
  logic [DW-1:0][6:0]       disp_dst_preg;
  logic [DW-1:0][31:0]      disp_pc;
  logic                     disp_ready;
  logic [DW-1:0][5:0]       disp_rob_idx;
  logic [NC-1:0]            cpl_valid, cpl_exception, cpl_br_mispred;
  logic [NC-1:0][5:0]       cpl_rob_idx;
  logic [RW-1:0]            ret_valid, ret_exception, ret_br_mispred;
  logic [RW-1:0][4:0]       ret_dst_areg;
  logic [RW-1:0][6:0]       ret_dst_preg;
  logic [RW-1:0][31:0]      ret_pc;
  logic                     flush;
  logic [5:0]               flush_rob_idx;
  logic [6:0]               count;

  rob_ring dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_dst_areg(disp_dst_areg), .disp_dst_preg(disp_dst_preg),
    .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
    .cpl_valid(cpl_valid), .cpl_rob_idx(cpl_rob_idx), .cpl_exception(cpl_exception),
    .cpl_br_mispred(cpl_br_mispred), .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg),
    .ret_dst_preg(ret_dst_preg), .ret_pc(ret_pc), .ret_exception(ret_exception),
    .ret_br_mispred(ret_br_mispred), .flush(flush), .flush_rob_idx(flush_rob_idx), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] pc;
    logic [4:0]  areg;
    logic [6:0]  preg;
    bit          done, exc, bm;
  } ent_t;

  typedef struct {
    logic [3:0] cmask, exc, bm, exp_ret;
    logic       exp_flush;
    logic [5:0] exp_fidx;
  } vec_t;

  ent_t        q[$];
  vec_t        tbl[9];
  int          n_tests = 0, n_fail = 0, vec_k = -1;
  logic [5:0]  m_tail = '0;
  logic [31:0] pcn = 32'h1000;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic disp(int n);
    for (int i = 0; i < n; i++) begin
      disp_valid[i]    = 1'b1;
      disp_pc[i]       = pcn;
      disp_dst_areg[i] = 5'($urandom);
      disp_dst_preg[i] = 7'($urandom);
      pcn += 4;
    end
  endtask

  task automatic cpl(int p, logic [5:0] idx, bit e = 0, bit b = 0);
    cpl_valid[p]      = 1'b1;
    cpl_rob_idx[p]    = idx;
    cpl_exception[p]  = e;
    cpl_br_mispred[p] = b;
  endtask

  // Called at posedge+1 with inputs set: checks mid-cycle outputs against the queue, then advances the model.
  task automatic cycle();
    int nr = 0;
    bit ef = 0, stop = 0, er;
    logic [5:0] fi = '0;
    logic [3:0] mask;
    ent_t e;
    #3;
    for (int k = 0; k < RW; k++)
      if (!stop && k < q.size() && q[k].done) begin
        nr++;
        if (q[k].exc || q[k].bm) begin
          ef = 1;
          fi = q[k].idx;
          stop = 1;
        end
      end else stop = 1;
    mask = 4'((1 << nr) - 1);
    chk("ret_valid", ret_valid, mask);
    for (int k = 0; k < nr; k++) begin
      chk("ret_pc", ret_pc[k], q[k].pc);
      chk("ret_areg", ret_dst_areg[k], q[k].areg);
      chk("ret_preg", ret_dst_preg[k], q[k].preg);
      chk("ret_exc", ret_exception[k], q[k].exc);
      chk("ret_bm", ret_br_mispred[k], q[k].bm);
    end
    chk("flush", flush, ef);
    if (ef) chk("flush_idx", flush_rob_idx, fi);
    chk("count", count, q.size());
    er = !ef && q.size() <= N - DW;
    chk("disp_ready", disp_ready, er);
    for (int i = 0; i < DW; i++) chk("disp_idx", disp_rob_idx[i], 6'(m_tail + i));
    if (vec_k >= 0) begin
      chk("vec_ret", ret_valid, tbl[vec_k].exp_ret);
      chk("vec_flush", flush, tbl[vec_k].exp_flush);
      if (tbl[vec_k].exp_flush) chk("vec_fidx", flush_rob_idx, tbl[vec_k].exp_fidx);
    end
    if (!rst_n || ef) begin
      q.delete();
      m_tail = '0;
    end else begin
      repeat (nr) void'(q.pop_front());
      for (int p = 0; p < NC; p++)
        if (cpl_valid[p])
          for (int j = 0; j < q.size(); j++)
            if (q[j].idx == cpl_rob_idx[p]) begin
              e = q[j];
              e.done = 1;
              e.exc = e.exc | cpl_exception[p];
              e.bm  = e.bm | cpl_br_mispred[p];
              q[j] = e;
            end
      if (er)
        for (int i = 0; i < DW; i++)
          if (disp_valid[i]) begin
            q.push_back('{m_tail, disp_pc[i], disp_dst_areg[i], disp_dst_preg[i], 0, 0, 0});
            m_tail++;
          end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    disp_valid = '0;
    cpl_valid = '0;
    cpl_exception = '0;
    cpl_br_mispred = '0;
    vec_k = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int np;
    disp_valid = '0; disp_dst_areg = '0; disp_dst_preg = '0; disp_pc = '0;
    cpl_valid = '0; cpl_rob_idx = '0; cpl_exception = '0; cpl_br_mispred = '0;
    tbl[0] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 6'd0};
    tbl[1] = '{4'b1111, 4'b0000, 4'b0100, 4'b0111, 1'b1, 6'd2};
    tbl[2] = '{4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 6'd0};
    tbl[3] = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b0, 6'd0};
    tbl[4] = '{4'b1111, 4'b0001, 4'b0000, 4'b0001, 1'b1, 6'd0};
    tbl[5] = '{4'b1011, 4'b0000, 4'b0000, 4'b0011, 1'b0, 6'd0};
    tbl[6] = '{4'b1111, 4'b1000, 4'b0000, 4'b1111, 1'b1, 6'd3};
    tbl[7] = '{4'b0111, 4'b0000, 4'b0010, 4'b0011, 1'b1, 6'd1};
    tbl[8] = '{4'b1111, 4'b0100, 4'b0100, 4'b0111, 1'b1, 6'd2};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    cycle();
    for (int v = 0; v < 9; v++) begin
      rst_n = 1'b0;
      cycle();
      disp(2); cycle();
      disp(2); cycle();
      for (int p = 0; p < 4; p++)
        if (tbl[v].cmask[p]) cpl(p, 6'(p), tbl[v].exc[p], tbl[v].bm[p]);
      cycle();
      vec_k = v;
      cycle();
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    for (int c = 0; c < 32; c++) begin
      disp(2);
      cycle();
    end
    disp(2); cycle();
    for (int p = 0; p < 4; p++) cpl(p, 6'(p));
    cycle();
    for (int p = 0; p < 4; p++) cpl(p, 6'(4 + p));
    cycle();
    cycle();
    cycle();
    cpl(0, 6'd9); cycle();
    cycle();
    cpl(0, 6'd8); cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    disp(2); cycle();
    cpl(0, 6'd0, 1, 0); cycle();
    rst_n = 1'b0;
    cycle();
    cycle();
    for (int c = 0; c < 200; c++) begin
      disp(2);
      np = 0;
      if (c == 121) begin
        cpl(0, 6'd40);
        cpl(1, 6'd41);
      end else
        for (int j = 0; j < q.size() && j < 8 && np < 4; j++)
          if (!q[j].done && $urandom_range(0, 3) != 0) begin
            cpl(np, q[j].idx);
            np++;
          end
      if (c == 120) rst_n = 1'b0;
      cycle();
    end
    repeat (4) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
